mem_port_arbiter: RTL and testbench

- Shares one external memory port between the instruction-side and data-side last-level caches.
- Sits between the I and D cache next-level interfaces and the chip memory port, so the chip can run with a single unified memory.
- Serves one outstanding transaction at a time. Requests are latched at grant and replayed unchanged to memory.
- Arbitration is round-robin, or D-priority with a starvation limit for I.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-side and D-side caches, one transaction at a time.
// Arbitration is round-robin (mode 0) or D-priority with an I starvation guard (mode 1).
module mem_port_arbiter #(
  parameter int BW_ADDRESS    = 32,
  parameter int BW_BLOCK      = 128,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_CONSEC    = 4,
  parameter int BW_CNT        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_valid,
  input  logic                  I_r0w1,
  input  logic [BW_ADDRESS-1:0] I_rwaddr,
  input  logic [BW_BLOCK-1:0]   I_wdata,
  output logic                  I_ready,
  output logic [BW_BLOCK-1:0]   I_rdata,
  input  logic                  D_valid,
  input  logic                  D_r0w1,
  input  logic [BW_ADDRESS-1:0] D_rwaddr,
  input  logic [BW_BLOCK-1:0]   D_wdata,
  output logic                  D_ready,
  output logic [BW_BLOCK-1:0]   D_rdata,
  output logic                  mem_valid,
  output logic                  mem_r0w1,
  output logic [BW_ADDRESS-1:0] mem_rwaddr,
  output logic [BW_BLOCK-1:0]   mem_wdata,
  input  logic                  mem_ready,
  input  logic [BW_BLOCK-1:0]   mem_rdata,
  output logic                  busy,
  output logic                  owner,
  output logic [BW_CNT-1:0]     num_I_grant,
  output logic [BW_CNT-1:0]     num_D_grant
);

  localparam int BW_CONSEC = $clog2(MAX_CONSEC + 1);
  localparam logic [BW_CONSEC-1:0] CONSEC_LIMIT = BW_CONSEC'(MAX_CONSEC);
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [BW_CONSEC-1:0]    consec_q, consec_d;
  logic                    r0w1_q, r0w1_d;
  logic [BW_ADDRESS-1:0]   addr_q, addr_d;
  logic [BW_BLOCK-1:0]     wdata_q, wdata_d;
  logic [BW_CNT-1:0]       num_i_q, num_i_d;
  logic [BW_CNT-1:0]       num_d_q, num_d_d;
  logic                    grant;
  logic                    grant_side;
  logic                    complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_D;
      consec_q     <= '0;
      r0w1_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      num_i_q      <= '0;
      num_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      consec_q     <= consec_d;
      r0w1_q       <= r0w1_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      num_i_q      <= num_i_d;
      num_d_q      <= num_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    consec_d     = consec_q;
    r0w1_d       = r0w1_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    num_i_d      = num_i_q;
    num_d_d      = num_d_q;
    grant        = 1'b0;
    grant_side   = SIDE_I;
    case (state_q)
      IDLE: begin
        if (I_valid || D_valid) begin
          grant = 1'b1;
          if (!D_valid)                grant_side = SIDE_I;
          else if (!I_valid)           grant_side = SIDE_D;
          else if (PRIORITY_MODE == 0) grant_side = ~last_grant_q;
          else                         grant_side = (consec_q == CONSEC_LIMIT) ? SIDE_I : SIDE_D;
        end
        if (grant) begin
          state_d      = BUSY;
          owner_d      = grant_side;
          last_grant_d = grant_side;
          if (grant_side == SIDE_I) begin
            r0w1_d   = I_r0w1;
            addr_d   = I_rwaddr;
            wdata_d  = I_wdata;
            num_i_d  = num_i_q + BW_CNT'(1);
            consec_d = '0;
          end else begin
            r0w1_d  = D_r0w1;
            addr_d  = D_rwaddr;
            wdata_d = D_wdata;
            num_d_d = num_d_q + BW_CNT'(1);
            // Only D grants that made a waiting I lose count towards starvation.
            if (I_valid && (consec_q != CONSEC_LIMIT)) consec_d = consec_q + BW_CONSEC'(1);
          end
        end
      end
      BUSY: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    complete    = (state_q == BUSY) && mem_ready;
    busy        = (state_q == BUSY);
    owner       = owner_q;
    mem_valid   = (state_q == BUSY);
    mem_r0w1    = r0w1_q;
    mem_rwaddr  = addr_q;
    mem_wdata   = wdata_q;
    num_I_grant = num_i_q;
    num_D_grant = num_d_q;
    I_ready     = complete && (owner_q == SIDE_I);
    D_ready     = complete && (owner_q == SIDE_D);
    I_rdata     = (complete && (owner_q == SIDE_I)) ? mem_rdata : '0;
    D_rdata     = (complete && (owner_q == SIDE_D)) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized round-robin run
// compared against a simple arbitration model; a second instance exercises D-priority mode.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int BW = 128;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic a_iv, a_ir, a_irdy, a_dv, a_dr, a_drdy, a_mv, a_mr, a_mrdy, a_busy, a_own;
  logic [AW-1:0] a_ia, a_da, a_ma;
  logic [BW-1:0] a_iw, a_ird, a_dw, a_drd, a_mw, a_mrd;
  logic [CW-1:0] a_ni, a_nd;

  logic b_iv, b_ir, b_irdy, b_dv, b_dr, b_drdy, b_mv, b_mr, b_mrdy, b_busy, b_own;
  logic [AW-1:0] b_ia, b_da, b_ma;
  logic [BW-1:0] b_iw, b_ird, b_dw, b_drd, b_mw, b_mrd;
  logic [CW-1:0] b_ni, b_nd;

  mem_port_arbiter #(.BW_ADDRESS(AW), .BW_BLOCK(BW), .PRIORITY_MODE(0), .MAX_CONSEC(4), .BW_CNT(CW)) dut_a (
    .clk(clk), .rst(rst),
    .I_valid(a_iv), .I_r0w1(a_ir), .I_rwaddr(a_ia), .I_wdata(a_iw), .I_ready(a_irdy), .I_rdata(a_ird),
    .D_valid(a_dv), .D_r0w1(a_dr), .D_rwaddr(a_da), .D_wdata(a_dw), .D_ready(a_drdy), .D_rdata(a_drd),
    .mem_valid(a_mv), .mem_r0w1(a_mr), .mem_rwaddr(a_ma), .mem_wdata(a_mw),
    .mem_ready(a_mrdy), .mem_rdata(a_mrd),
    .busy(a_busy), .owner(a_own), .num_I_grant(a_ni), .num_D_grant(a_nd)
  );

  mem_port_arbiter #(.BW_ADDRESS(AW), .BW_BLOCK(BW), .PRIORITY_MODE(1), .MAX_CONSEC(2), .BW_CNT(CW)) dut_b (
    .clk(clk), .rst(rst),
    .I_valid(b_iv), .I_r0w1(b_ir), .I_rwaddr(b_ia), .I_wdata(b_iw), .I_ready(b_irdy), .I_rdata(b_ird),
    .D_valid(b_dv), .D_r0w1(b_dr), .D_rwaddr(b_da), .D_wdata(b_dw), .D_ready(b_drdy), .D_rdata(b_drd),
    .mem_valid(b_mv), .mem_r0w1(b_mr), .mem_rwaddr(b_ma), .mem_wdata(b_mw),
    .mem_ready(b_mrdy), .mem_rdata(b_mrd),
    .busy(b_busy), .owner(b_own), .num_I_grant(b_ni), .num_D_grant(b_nd)
  );

  function automatic logic [BW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a, a + 32'h1};
  endfunction

  // Memory model for instance a: either driven by hand or by an auto-responder with latency a_lat.
  bit a_auto = 1'b0;
  int a_lat = 0;
  logic a_mrdy_r, a_mrdy_m;
  logic [BW-1:0] a_mrd_r, a_mrd_m;
  logic [AW-1:0] a_cap_addr;
  logic a_cap_r0w1;
  logic [BW-1:0] a_cap_wdata;
  assign a_mrdy = a_auto ? a_mrdy_r : a_mrdy_m;
  assign a_mrd  = a_auto ? a_mrd_r : a_mrd_m;

  initial begin
    int cnt;
    cnt = 0;
    a_mrdy_r = 1'b0; a_mrd_r = '0;
    a_cap_addr = '0; a_cap_r0w1 = 1'b0; a_cap_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!a_auto || a_mrdy_r) begin
        a_mrdy_r = 1'b0; a_mrd_r = '0; cnt = 0;
      end else if (a_mv) begin
        if (cnt >= a_lat) begin
          a_mrdy_r = 1'b1; a_mrd_r = mem_fn(a_ma);
          a_cap_addr = a_ma; a_cap_r0w1 = a_mr; a_cap_wdata = a_mw;
        end else cnt++;
      end
    end
  end

  int b_lat = 1;
  initial begin
    int cnt;
    cnt = 0;
    b_mrdy = 1'b0; b_mrd = '0;
    forever begin
      @(posedge clk); #1;
      if (b_mrdy) begin
        b_mrdy = 1'b0; b_mrd = '0; cnt = 0;
      end else if (b_mv) begin
        if (cnt >= b_lat) begin b_mrdy = 1'b1; b_mrd = mem_fn(b_ma); end
        else cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_output(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // side: 0 = I ready, 1 = D ready, 2 = both, -1 = no ready within the budget
  task automatic wait_ready(input bit use_b, output int side);
    int n;
    logic ri, rd;
    n = 0;
    side = -1;
    while (side == -1 && n < 50) begin
      tick(); #1;
      ri = use_b ? b_irdy : a_irdy;
      rd = use_b ? b_drdy : a_drdy;
      if (ri && rd) side = 2;
      else if (ri) side = 0;
      else if (rd) side = 1;
      n++;
    end
  endtask

  initial begin
    int side, exp_side, prev, consec, last, ni, nd;
    logic [1:0] pat;
    logic ri, rd;
    logic [AW-1:0] ai, ad;
    logic [BW-1:0] wi, wd;
    logic [BW-1:0] dead_beef;

    dead_beef = 128'hDEAD0000_00000000_00000000_0000BEEF;
    rst = 1'b1;
    a_iv = 0; a_ir = 0; a_ia = '0; a_iw = '0; a_dv = 0; a_dr = 0; a_da = '0; a_dw = '0;
    b_iv = 0; b_ir = 0; b_ia = '0; b_iw = '0; b_dv = 0; b_dr = 0; b_da = '0; b_dw = '0;
    a_mrdy_m = 1'b0; a_mrd_m = '0;
    tick(); tick();
    rst = 1'b0; #1;

    check_output("rst_mem_valid", a_mv, 0);
    check_output("rst_busy", a_busy, 0);
    check_output("rst_owner", a_own, 0);
    check_output("rst_num_i", a_ni, 0);
    check_output("rst_num_d", a_nd, 0);
    check_output("rst_mem_addr", a_ma, 0);

    // Single I read of 0x100, memory answering three cycles after mem_valid.
    tick(); a_iv = 1; a_ir = 0; a_ia = 32'h100; a_iw = '0; #1;
    check_output("t1_no_early_valid", a_mv, 0);
    tick(); #1;
    check_output("t1_valid_rise", a_mv, 1);
    check_output("t1_addr", a_ma, 32'h100);
    check_output("t1_owner", a_own, 0);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      check_output("t1_no_ready_yet", a_irdy, 0);
      check_output("t1_valid_held", a_mv, 1);
    end
    tick(); a_mrdy_m = 1; a_mrd_m = dead_beef; #1;
    check_output("t1_i_ready", a_irdy, 1);
    check_output("t1_i_rdata", a_ird, dead_beef);
    check_output("t1_d_ready", a_drdy, 0);
    check_output("t1_d_rdata", a_drd, 0);
    tick(); a_mrdy_m = 0; a_mrd_m = '0; a_iv = 0; #1;
    check_output("t1_ready_once", a_irdy, 0);
    check_output("t1_idle", a_busy, 0);
    check_output("t1_valid_drop", a_mv, 0);
    check_output("t1_num_i", a_ni, 1);

    // D write with its inputs scrambled (and valid dropped) while the transaction is in flight.
    tick(); a_dv = 1; a_dr = 1; a_da = 32'h40; a_dw = {16{8'hA5}};
    tick(); #1;
    check_output("t4_busy", a_busy, 1);
    check_output("t4_owner", a_own, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      a_da = $urandom; a_dw = {$urandom, $urandom, $urandom, $urandom}; a_dr = 0;
      if (k == 1) a_dv = 0;
      #1;
      check_output("t4_r0w1", a_mr, 1);
      check_output("t4_addr", a_ma, 32'h40);
      check_output("t4_wdata", a_mw, {16{8'hA5}});
      check_output("t4_no_ready_yet", a_drdy, 0);
    end
    tick(); a_mrdy_m = 1; a_mrd_m = mem_fn(32'h40); #1;
    check_output("t4_d_ready", a_drdy, 1);
    check_output("t4_i_ready", a_irdy, 0);
    check_output("t4_i_rdata", a_ird, 0);
    tick(); a_mrdy_m = 0; a_mrd_m = '0; #1;
    check_output("t4_ready_once", a_drdy, 0);
    check_output("t4_idle", a_busy, 0);
    check_output("t4_num_d", a_nd, 1);

    // Stray mem_ready while idle.
    tick(); a_mrdy_m = 1; a_mrd_m = {4{32'h1234_5678}}; #1;
    check_output("t6_i_ready", a_irdy, 0);
    check_output("t6_d_ready", a_drdy, 0);
    check_output("t6_i_rdata", a_ird, 0);
    check_output("t6_d_rdata", a_drd, 0);
    tick(); a_mrdy_m = 0; a_mrd_m = '0; #1;
    check_output("t6_idle", a_busy, 0);
    check_output("t6_no_valid", a_mv, 0);
    check_output("t6_num_i", a_ni, 1);
    check_output("t6_num_d", a_nd, 1);

    // Reset two cycles into a BUSY I read; a late mem_ready must be ignored.
    tick(); a_iv = 1; a_ir = 0; a_ia = 32'h200; a_iw = {4{32'hCAFE_F00D}};
    tick(); #1;
    check_output("t5_busy", a_busy, 1);
    tick(); rst = 1; a_iv = 0;
    tick(); rst = 0; #1;
    check_output("t5_rst_valid", a_mv, 0);
    check_output("t5_rst_busy", a_busy, 0);
    check_output("t5_rst_owner", a_own, 0);
    check_output("t5_rst_num_i", a_ni, 0);
    check_output("t5_rst_num_d", a_nd, 0);
    check_output("t5_rst_addr", a_ma, 0);
    check_output("t5_rst_wdata", a_mw, 0);
    check_output("t5_rst_r0w1", a_mr, 0);
    tick(); a_mrdy_m = 1; a_mrd_m = mem_fn(32'h200); #1;
    check_output("t5_late_i_ready", a_irdy, 0);
    check_output("t5_late_d_ready", a_drdy, 0);
    tick(); a_mrdy_m = 0; a_mrd_m = '0; #1;
    check_output("t5_still_idle", a_busy, 0);
    tick(); a_iv = 1; a_ia = 32'h300; a_iw = '0;
    tick(); #1;
    check_output("t5_regrant", a_busy, 1);
    check_output("t5_regrant_num_i", a_ni, 1);
    check_output("t5_regrant_addr", a_ma, 32'h300);
    tick(); a_mrdy_m = 1; a_mrd_m = mem_fn(32'h300); #1;
    check_output("t5_i_ready", a_irdy, 1);
    check_output("t5_i_rdata", a_ird, mem_fn(32'h300));
    tick(); a_mrdy_m = 0; a_mrd_m = '0; a_iv = 0;

    // Round-robin with both sides requesting continuously from reset.
    tick();
    a_auto = 1; a_lat = $urandom_range(0, 3);
    a_iv = 1; a_ir = 0; a_ia = 32'h1000; a_dv = 1; a_dr = 0; a_da = 32'h2000;
    rst = 1;
    tick(); rst = 0;
    prev = 0;
    exp_side = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(1'b0, side);
      exp_side = 1 - exp_side;
      check_output("rr_order", side, exp_side);
      check_output("rr_rdata", (exp_side == 0) ? a_ird : a_drd, mem_fn((exp_side == 0) ? 32'h1000 : 32'h2000));
      if (k > 0) check_output("rr_gap", cyc - prev, a_lat + 2);
      prev = cyc;
    end
    tick(); a_iv = 0; a_dv = 0; #1;
    check_output("rr_idle_between", a_busy, 0);
    check_output("rr_num_i", a_ni, 2);
    check_output("rr_num_d", a_nd, 2);

    // D-priority with MAX_CONSEC = 2 on the second instance.
    tick();
    b_iv = 1; b_ir = 0; b_ia = 32'h3000; b_dv = 1; b_dr = 0; b_da = 32'h4000;
    consec = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ready(1'b1, side);
      if (consec == 2) begin exp_side = 0; consec = 0; end
      else begin exp_side = 1; consec++; end
      check_output("prio_order", side, exp_side);
      check_output("prio_rdata", (exp_side == 0) ? b_ird : b_drd, mem_fn((exp_side == 0) ? 32'h3000 : 32'h4000));
    end
    tick(); b_iv = 0; b_dv = 0; #1;
    check_output("prio_num_i", b_ni, 2);
    check_output("prio_num_d", b_nd, 4);

    // Randomized round-robin traffic against the arbitration model.
    tick(); rst = 1;
    tick(); rst = 0;
    last = 1; ni = 0; nd = 0;
    for (int k = 0; k < 30; k++) begin
      pat = 2'($urandom_range(1, 3));
      a_lat = $urandom_range(0, 3);
      ri = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      ai = $urandom; ad = $urandom;
      wi = {$urandom, $urandom, $urandom, $urandom};
      wd = {$urandom, $urandom, $urandom, $urandom};
      a_iv = pat[0]; a_ir = ri; a_ia = ai; a_iw = wi;
      a_dv = pat[1]; a_dr = rd; a_da = ad; a_dw = wd;
      if (pat == 2'b01) exp_side = 0;
      else if (pat == 2'b10) exp_side = 1;
      else exp_side = 1 - last;
      wait_ready(1'b0, side);
      check_output("rnd_side", side, exp_side);
      check_output("rnd_rdata", (exp_side == 0) ? a_ird : a_drd, mem_fn((exp_side == 0) ? ai : ad));
      check_output("rnd_mem_addr", a_cap_addr, (exp_side == 0) ? ai : ad);
      check_output("rnd_mem_r0w1", a_cap_r0w1, (exp_side == 0) ? ri : rd);
      check_output("rnd_mem_wdata", a_cap_wdata, (exp_side == 0) ? wi : wd);
      last = exp_side;
      if (exp_side == 0) ni++; else nd++;
      tick(); a_iv = 0; a_dv = 0;
    end
    #1;
    check_output("rnd_num_i", a_ni, ni);
    check_output("rnd_num_d", a_nd, nd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
